// File: rtl/ascon_pack.sv
// Shared types and round-index constants for the ASCON-128 permutation control.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_P12  = 3'd1,
    WAIT_AD   = 3'd2,
    AD_P6     = 3'd3,
    WAIT_PT   = 3'd4,
    PT_P6     = 3'd5,
    FINAL_P12 = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
  localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

endpackage

// File: rtl/ascon_round_ctrl.sv
// Control FSM sequencing the ASCON-128 permutation: init p12, AD p6, PT p6, final p12.
// Build option ASCON_EMPTY_AD_EN adds ad_empty_i, allowing a message with no AD block.
//
// state     | meaning
// IDLE      | waiting for start_i
// INIT_P12  | 12-round initialisation permutation
// WAIT_AD   | waiting for an associated-data block
// AD_P6     | 6-round permutation over an AD block
// WAIT_PT   | waiting for a plaintext block
// PT_P6     | 6-round permutation over a non-final PT block
// FINAL_P12 | 12-round finalisation, tag produced on last round
// DONE      | one-cycle completion pulse
module ascon_round_ctrl
  import ascon_pack::*;
#(
  parameter logic [3:0] LAST_ROUND = ROUND_LAST
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
`ifdef ASCON_EMPTY_AD_EN
  input  logic       ad_empty_i,
`endif
  input  logic       data_valid_i,
  input  logic       data_last_i,
  input  logic [3:0] cpt_i,
  output logic       data_ready_o,
  output logic       en_cpt_o,
  output logic       init_12_o,
  output logic       init_6_o,
  output logic       en_state_o,
  output logic       sel_init_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   dsep_q, dsep_d;
  // Marks that the next PT accept is the first one after the AD phase.
  logic   first_pt_q, first_pt_d;
  logic   skip_ad;
  logic   round_last;

`ifdef ASCON_EMPTY_AD_EN
  logic ad_empty_q, ad_empty_d;
  assign skip_ad = ad_empty_q;
`else
  assign skip_ad = 1'b0;
`endif

  assign round_last = (cpt_i == LAST_ROUND);
  assign busy_o     = (state_q != IDLE);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b0;
      dsep_q     <= 1'b0;
      first_pt_q <= 1'b0;
`ifdef ASCON_EMPTY_AD_EN
      ad_empty_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      dsep_q     <= dsep_d;
      first_pt_q <= first_pt_d;
`ifdef ASCON_EMPTY_AD_EN
      ad_empty_q <= ad_empty_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    dsep_d          = dsep_q;
    first_pt_d      = first_pt_q;
`ifdef ASCON_EMPTY_AD_EN
    ad_empty_d      = ad_empty_q;
`endif
    data_ready_o    = 1'b0;
    en_cpt_o        = 1'b0;
    init_12_o       = 1'b0;
    init_6_o        = 1'b0;
    en_state_o      = 1'b0;
    sel_init_o      = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_o       = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    done_o          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          sel_init_o = 1'b1;
          en_state_o = 1'b1;
          en_cpt_o   = 1'b1;
          init_12_o  = 1'b1;
          last_d     = 1'b0;
          dsep_d     = 1'b0;
          first_pt_d = 1'b0;
`ifdef ASCON_EMPTY_AD_EN
          ad_empty_d = ad_empty_i;
`endif
          state_d    = INIT_P12;
        end
      end

      INIT_P12: begin
        en_state_o = 1'b1;
        en_cpt_o   = 1'b1;
        if (round_last) begin
          xor_key_end_o = 1'b1;
          if (skip_ad) begin
            dsep_d  = 1'b1;
            state_d = WAIT_PT;
          end else begin
            state_d = WAIT_AD;
          end
        end
      end

      WAIT_AD: begin
        data_ready_o = data_valid_i;
        if (data_valid_i) begin
          en_cpt_o = 1'b1;
          init_6_o = 1'b1;
          last_d   = data_last_i;
          state_d  = AD_P6;
        end
      end

      AD_P6: begin
        en_state_o = 1'b1;
        en_cpt_o   = 1'b1;
        xor_data_o = (cpt_i == ROUND_P6_FIRST);
        if (round_last) begin
          if (last_q) begin
            first_pt_d = 1'b1;
            state_d    = WAIT_PT;
          end else begin
            state_d = WAIT_AD;
          end
        end
      end

      WAIT_PT: begin
        data_ready_o = data_valid_i;
        if (data_valid_i) begin
          en_cipher_o = 1'b1;
          en_cpt_o    = 1'b1;
          if (first_pt_q) begin
            dsep_d     = 1'b1;
            first_pt_d = 1'b0;
          end
          if (data_last_i) begin
            init_12_o = 1'b1;
            state_d   = FINAL_P12;
          end else begin
            init_6_o = 1'b1;
            state_d  = PT_P6;
          end
        end
      end

      PT_P6: begin
        en_state_o = 1'b1;
        en_cpt_o   = 1'b1;
        if (cpt_i == ROUND_P6_FIRST) begin
          xor_data_o = 1'b1;
          xor_lsb_o  = dsep_q;
          dsep_d     = 1'b0;
        end
        if (round_last) state_d = WAIT_PT;
      end

      FINAL_P12: begin
        en_state_o = 1'b1;
        en_cpt_o   = 1'b1;
        // A single-block PT message still owes its domain separation here.
        if (cpt_i == ROUND_P12_FIRST) begin
          xor_data_o      = 1'b1;
          xor_key_begin_o = 1'b1;
          xor_lsb_o       = dsep_q;
          dsep_d          = 1'b0;
        end
        if (round_last) begin
          xor_key_end_o = 1'b1;
          en_tag_o      = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl with a behavioural round counter alongside.
module tb_ascon_round_ctrl;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic       data_valid_i;
  logic       data_last_i;
  logic [3:0] cpt_i;
`ifdef ASCON_EMPTY_AD_EN
  logic       ad_empty_i;
`endif
  logic data_ready_o, en_cpt_o, init_12_o, init_6_o, en_state_o, sel_init_o;
  logic xor_data_o, xor_key_begin_o, xor_key_end_o, xor_lsb_o;
  logic en_cipher_o, en_tag_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [13:0] RDY   = 14'h2000;
  localparam logic [13:0] ECPT  = 14'h1000;
  localparam logic [13:0] I12   = 14'h0800;
  localparam logic [13:0] I6    = 14'h0400;
  localparam logic [13:0] EST   = 14'h0200;
  localparam logic [13:0] SINIT = 14'h0100;
  localparam logic [13:0] XDATA = 14'h0080;
  localparam logic [13:0] KBEG  = 14'h0040;
  localparam logic [13:0] KEND  = 14'h0020;
  localparam logic [13:0] LSB   = 14'h0010;
  localparam logic [13:0] CIPH  = 14'h0008;
  localparam logic [13:0] TAG   = 14'h0004;
  localparam logic [13:0] BUSY  = 14'h0002;
  localparam logic [13:0] DONEB = 14'h0001;
  localparam logic [13:0] PBASE = BUSY | ECPT | EST;

  logic [13:0] outs;
  assign outs = {data_ready_o, en_cpt_o, init_12_o, init_6_o, en_state_o, sel_init_o,
                 xor_data_o, xor_key_begin_o, xor_key_end_o, xor_lsb_o,
                 en_cipher_o, en_tag_o, busy_o, done_o};

  ascon_round_ctrl dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
`ifdef ASCON_EMPTY_AD_EN
    .ad_empty_i      (ad_empty_i),
`endif
    .data_valid_i    (data_valid_i),
    .data_last_i     (data_last_i),
    .cpt_i           (cpt_i),
    .data_ready_o    (data_ready_o),
    .en_cpt_o        (en_cpt_o),
    .init_12_o       (init_12_o),
    .init_6_o        (init_6_o),
    .en_state_o      (en_state_o),
    .sel_init_o      (sel_init_o),
    .xor_data_o      (xor_data_o),
    .xor_key_begin_o (xor_key_begin_o),
    .xor_key_end_o   (xor_key_end_o),
    .xor_lsb_o       (xor_lsb_o),
    .en_cipher_o     (en_cipher_o),
    .en_tag_o        (en_tag_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clock_i = ~clock_i;

  // Sibling round counter: load 0 / load 6 / increment.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i)      cpt_i <= 4'd0;
    else if (en_cpt_o) begin
      if (init_12_o)     cpt_i <= 4'd0;
      else if (init_6_o) cpt_i <= 4'd6;
      else               cpt_i <= cpt_i + 4'd1;
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    resetb_i     = 1'b0;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
`ifdef ASCON_EMPTY_AD_EN
    ad_empty_i   = 1'b0;
`endif
    repeat (2) @(posedge clock_i);
    #1;
    resetb_i = 1'b1;
  endtask

  // Start pulse plus the 12 init rounds; leaves the DUT in the first wait state.
  task automatic run_init();
    logic [13:0] exp;
    start_i = 1'b1;
    #1;
    exp = SINIT | EST | ECPT | I12;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL start_cycle: got %h want %h", outs, exp);
    end
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp = PBASE | ((i == 11) ? KEND : 14'h0);
      checks++;
      if (outs !== exp || cpt_i !== 4'(i)) begin
        failures++;
        $display("FAIL init_round %0d: got %h cpt %0d want %h cpt %0d", i, outs, cpt_i, exp, i);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    data_valid_i = 1'b1;
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL reset_idle: got %h want 0000", outs);
    end
    tick();
    #1;
    checks++;
    if (outs !== 14'h0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid_ignored: got %h want 0000", outs);
    end
    data_valid_i = 1'b0;
    tick();
  endtask

  // One AD block (last) then two PT blocks; PT data held valid during AD_P6.
  task automatic test_full_message();
    logic [13:0] exp;
    run_init();
    start_i = 1'b1;
    #1;
    checks++;
    if (outs !== BUSY) begin
      failures++;
      $display("FAIL wait_ad_start_ignored: got %h want %h", outs, BUSY);
    end
    tick();
    start_i      = 1'b0;
    data_valid_i = 1'b1;
    data_last_i  = 1'b1;
    #1;
    exp = RDY | ECPT | I6 | BUSY;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL ad_accept: got %h want %h", outs, exp);
    end
    tick();
    data_last_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = PBASE | ((i == 0) ? XDATA : 14'h0);
      checks++;
      if (outs !== exp || cpt_i !== 4'(6 + i)) begin
        failures++;
        $display("FAIL ad_p6 %0d: got %h cpt %0d want %h cpt %0d", i, outs, cpt_i, exp, 6 + i);
      end
      tick();
    end
    #1;
    exp = RDY | ECPT | I6 | CIPH | BUSY;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL pt1_accept: got %h want %h", outs, exp);
    end
    tick();
    data_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = PBASE | ((i == 0) ? (XDATA | LSB) : 14'h0);
      checks++;
      if (outs !== exp || cpt_i !== 4'(6 + i)) begin
        failures++;
        $display("FAIL pt1_p6 %0d: got %h cpt %0d want %h cpt %0d", i, outs, cpt_i, exp, 6 + i);
      end
      tick();
    end
    data_valid_i = 1'b1;
    data_last_i  = 1'b1;
    #1;
    exp = RDY | ECPT | I12 | CIPH | BUSY;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL pt2_accept: got %h want %h", outs, exp);
    end
    tick();
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp = PBASE | ((i == 0) ? (XDATA | KBEG) : 14'h0) | ((i == 11) ? (KEND | TAG) : 14'h0);
      checks++;
      if (outs !== exp || cpt_i !== 4'(i)) begin
        failures++;
        $display("FAIL final_round %0d: got %h cpt %0d want %h cpt %0d", i, outs, cpt_i, exp, i);
      end
      tick();
    end
    #1;
    checks++;
    if (outs !== (BUSY | DONEB)) begin
      failures++;
      $display("FAIL done_pulse: got %h want %h", outs, BUSY | DONEB);
    end
    tick();
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL back_to_idle: got %h want 0000", outs);
    end
    tick();
  endtask

  // Two AD blocks, then a single last PT block: domain separation lands in the final p12.
  task automatic test_multi_ad_single_pt();
    logic [13:0] exp;
    run_init();
    for (int blk = 0; blk < 2; blk++) begin
      data_valid_i = 1'b1;
      data_last_i  = (blk == 1);
      #1;
      exp = RDY | ECPT | I6 | BUSY;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL ad_accept_blk %0d: got %h want %h", blk, outs, exp);
      end
      tick();
      data_valid_i = 1'b0;
      data_last_i  = 1'b0;
      for (int i = 0; i < 6; i++) begin
        #1;
        exp = PBASE | ((i == 0) ? XDATA : 14'h0);
        checks++;
        if (outs !== exp || cpt_i !== 4'(6 + i)) begin
          failures++;
          $display("FAIL ad_blk%0d_p6 %0d: got %h cpt %0d want %h", blk, i, outs, cpt_i, exp);
        end
        tick();
      end
    end
    #1;
    checks++;
    if (outs !== BUSY) begin
      failures++;
      $display("FAIL wait_pt_idle: got %h want %h", outs, BUSY);
    end
    tick();
    data_valid_i = 1'b1;
    data_last_i  = 1'b1;
    #1;
    exp = RDY | ECPT | I12 | CIPH | BUSY;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL single_pt_accept: got %h want %h", outs, exp);
    end
    tick();
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp = PBASE | ((i == 0) ? (XDATA | KBEG | LSB) : 14'h0) | ((i == 11) ? (KEND | TAG) : 14'h0);
      checks++;
      if (outs !== exp || cpt_i !== 4'(i)) begin
        failures++;
        $display("FAIL single_final %0d: got %h cpt %0d want %h cpt %0d", i, outs, cpt_i, exp, i);
      end
      tick();
    end
    #1;
    checks++;
    if (outs !== (BUSY | DONEB)) begin
      failures++;
      $display("FAIL single_done: got %h want %h", outs, BUSY | DONEB);
    end
    tick();
  endtask

  task automatic test_reset_mid_init();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    #1;
    checks++;
    if (outs !== PBASE || cpt_i !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset: got %h cpt %0d want %h cpt 5", outs, cpt_i, PBASE);
    end
    resetb_i = 1'b0;
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL reset_mid_init: got %h want 0000", outs);
    end
    resetb_i = 1'b1;
    tick();
    #1;
    checks++;
    if (outs !== 14'h0) begin
      failures++;
      $display("FAIL post_reset_idle: got %h want 0000", outs);
    end
    tick();
    run_init();
    #1;
    checks++;
    if (outs !== BUSY) begin
      failures++;
      $display("FAIL reinit_wait_ad: got %h want %h", outs, BUSY);
    end
    do_reset();
  endtask

`ifdef ASCON_EMPTY_AD_EN
  task automatic test_empty_ad();
    logic [13:0] exp;
    do_reset();
    ad_empty_i = 1'b1;
    run_init();
    ad_empty_i   = 1'b0;
    data_valid_i = 1'b1;
    #1;
    exp = RDY | ECPT | I6 | CIPH | BUSY;
    checks++;
    if (outs !== exp) begin
      failures++;
      $display("FAIL empty_ad_pt_accept: got %h want %h", outs, exp);
    end
    tick();
    data_valid_i = 1'b0;
    #1;
    exp = PBASE | XDATA | LSB;
    checks++;
    if (outs !== exp || cpt_i !== 4'd6) begin
      failures++;
      $display("FAIL empty_ad_first_pt: got %h cpt %0d want %h cpt 6", outs, cpt_i, exp);
    end
    do_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_message();
    test_multi_ad_single_pt();
    test_reset_mid_init();
`ifdef ASCON_EMPTY_AD_EN
    test_empty_ad();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
Name: ascon_round_ctrl

Overview:
- Control FSM for the ASCON-128 permutation datapath.
- Issues load/enable commands to the round counter (`en_cpt_o`, `init_12_o`, `init_6_o`) and consumes its count (`cpt_i`).
- Also drives state-register and XOR selects, and performs the block handshake with the data source.
- Sequence: init p12 -> AD blocks (p6) -> PT blocks (p6) -> final p12 -> tag.

Parameters:
- `LAST_ROUND`, 11, counter value of the final round of both p12 and p6.

Ports:
- `clock_i` in 1: clock.
- `resetb_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: start one encryption; sampled in IDLE only.
- `data_valid_i` in 1: a 64-bit block is presented.
- `data_last_i` in 1: the presented block is the last of the current phase (AD or PT).
- `cpt_i` in 4: round count from the round counter.
- `data_ready_o` out 1: block accepted this cycle.
- `en_cpt_o` out 1: round counter enable.
- `init_12_o` out 1: counter load 0, qualified by `en_cpt_o`.
- `init_6_o` out 1: counter load 6, qualified by `en_cpt_o`.
- `en_state_o` out 1: state register write.
- `sel_init_o` out 1: load IV||K||N into state.
- `xor_data_o` out 1: XOR the block into the state rate at permutation input.
- `xor_key_begin_o` out 1: XOR the key at permutation input.
- `xor_key_end_o` out 1: XOR the key at permutation output.
- `xor_lsb_o` out 1: domain-separation XOR of bit 0 at permutation input.
- `en_cipher_o` out 1: capture ciphertext.
- `en_tag_o` out 1: capture tag.
- `busy_o` out 1: not IDLE.
- `done_o` out 1: one-cycle completion pulse.

Behaviour:
- State register is asynchronously reset to IDLE.
- Outputs are decoded from state plus inputs. With `start_i` = 0 in IDLE, every output is 0.
- States: IDLE, INIT_P12, WAIT_AD, AD_P6, WAIT_PT, PT_P6, FINAL_P12, DONE.
- **IDLE**
  - On `start_i`: assert `sel_init_o`, `en_state_o`, `en_cpt_o`, `init_12_o`; go to INIT_P12.
- **INIT_P12**
  - `en_state_o` = `en_cpt_o` = 1 every cycle; one round per cycle, `cpt_i` 0..11.
  - When `cpt_i` == `LAST_ROUND`: assert `xor_key_end_o`; go to WAIT_AD.
  - Duration: 12 cycles.
- **WAIT_AD**
  - `data_ready_o` = `data_valid_i`.
  - On `data_valid_i`: assert `en_cpt_o`, `init_6_o`; go to AD_P6.
  - `data_last_i` is registered as `last_q`.
- **AD_P6**
  - Rounds `cpt_i` 6..11.
  - `xor_data_o` is asserted when `cpt_i` == 6.
  - At `LAST_ROUND`: go to WAIT_PT if `last_q`, else WAIT_AD.
- **WAIT_PT**
  - `data_ready_o` = `data_valid_i`.
  - On accept, assert `en_cipher_o`; the first PT block after AD also sets `dsep_q`.
  - If `data_last_i` = 0: `en_cpt_o`, `init_6_o`; go to PT_P6.
  - If `data_last_i` = 1: `en_cpt_o`, `init_12_o`; go to FINAL_P12.
- **PT_P6**
  - `xor_data_o` at `cpt_i` == 6.
  - `xor_lsb_o` at `cpt_i` == 6 when `dsep_q`, which is then cleared.
  - At `LAST_ROUND`: go to WAIT_PT.
- **FINAL_P12**
  - At `cpt_i` == 0: `xor_data_o`, `xor_key_begin_o`, and `xor_lsb_o` if `dsep_q` is still set (single-PT-block message).
  - At `LAST_ROUND`: `xor_key_end_o`, `en_tag_o`; go to DONE.
- **DONE**
  - `done_o` = 1 for one cycle; go to IDLE unconditionally.
- Boundary rules:
  - `start_i` is ignored outside IDLE.
  - `data_valid_i` is ignored in IDLE, P-states and DONE (`data_ready_o` = 0).
  - Reset mid-operation returns to IDLE and clears `last_q`/`dsep_q`; the counter is reset independently.
- Latency: `start_i` at cycle t -> `data_ready_o` possible at t+13. Each p6 block takes 6 cycles. Final takes 12 cycles, then `done_o` 1 cycle later.

Optional Feature:
- `ASCON_EMPTY_AD_EN` defined:
  - Adds input `ad_empty_i`, sampled with `start_i` into `ad_empty_q`.
  - When set, INIT_P12 at `LAST_ROUND` goes directly to WAIT_PT; `dsep_q` is set at that transition.
- `ASCON_EMPTY_AD_EN` undefined:
  - Port absent; at least one AD block is mandatory.

Decomposition:
- Constants in `ascon_pack`:
  - `state_t` enum for the FSM states.
  - `ROUND_P12_FIRST` = 0, `ROUND_P6_FIRST` = 6, `ROUND_LAST` = 11.
- No sub-module.
- The round counter and permutation remain siblings, connected in the ascon top.

Test Plan:
- Reset then idle, `start_i` = 0 -> all outputs 0, `busy_o` = 0.
- `start_i` pulse at t -> `sel_init_o`/`init_12_o` at t; `xor_key_end_o` at t+12 with `cpt_i` = 11; `data_ready_o` allowed from t+13.
- 1 AD block (`last`) + 2 PT blocks:
  - AD: `init_6_o` on accept, `xor_data_o` at `cpt_i` 6.
  - PT1: `xor_lsb_o` at `cpt_i` 6 of its p6, `en_cipher_o` on each PT accept.
  - PT2 (`last`): `init_12_o`, then `xor_key_begin_o` at `cpt_i` 0, `en_tag_o` at 11, then `done_o`.
- `data_valid_i` held high during AD_P6 -> `data_ready_o` = 0 for all 6 round cycles; accepted only in WAIT state.
- `resetb_i` pulsed low at `cpt_i` = 5 of INIT_P12 -> immediate IDLE; next start produces a clean 12-round init.
- With `ASCON_EMPTY_AD_EN` and `ad_empty_i` = 1 -> WAIT_PT directly after init; `xor_lsb_o` on the first PT permutation.
